// File: rtl/frame_float_sequencer.sv
// frame_float_sequencer
// Walks one frame of signed 16-bit pixels out of the frame RAM in address
// order and drives each value onto the shared int16-to-float converter for
// two stable cycles. Each float result is captured into a small
// first-word-fall-through FIFO and streamed out on a valid/ready port.
// Reads are credit-limited so that every issued pixel always has a FIFO slot.
module frame_float_sequencer #(
    parameter int PIXELS     = 768,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic [15:0]       conv_int,
    input  logic [31:0]       conv_float,
    output logic              m_valid,
    output logic [31:0]       m_data,
    output logic              m_last,
    input  logic              m_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
    localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic   issue_d;

    // Valid/last travel with the pixel: p0 = rd_data valid, p1/p2 = conv_int
    // held stable for the converter, p3 = converter result ready to push.
    logic vld_p0, vld_p1, vld_p2, vld_p3;
    logic last_p0, last_p1, last_p2, last_p3;
    logic signed [15:0] conv_int_p1;

    logic [1:0]       inflight;
    logic [32:0]      fifo_mem [FIFO_DEPTH];
    logic [32:0]      fifo_head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             push, pop;
    logic [CNT_W:0]   credit_used;

    assign push      = vld_p3;
    assign m_valid   = (fifo_count != '0);
    assign pop       = m_valid && m_ready;
    assign fifo_head = fifo_mem[rd_ptr];
    assign m_data    = fifo_head[31:0];
    assign m_last    = m_valid && fifo_head[32];
    assign conv_int  = conv_int_p1;
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);

    // Credits held after this cycle: a push only moves a pixel from inflight
    // into the FIFO, so it leaves the total unchanged.
    always_comb begin
        credit_used = {1'b0, fifo_count} + (CNT_W + 1)'(inflight)
                    + (CNT_W + 1)'(rd_en) - (CNT_W + 1)'(pop);
    end

    // Next-state and read-issue decision; an issue cycle is always followed
    // by a gap cycle, which forms the two-cycle issue phase.
    always_comb begin
        state_d = state_q;
        issue_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    issue_d = 1'b1;
                end
            end
            S_RUN: begin
                if (rd_en && (rd_addr == LAST_ADDR)) begin
                    state_d = S_DRAIN;
                end else if (!rd_en && (credit_used < DEPTH_C)) begin
                    issue_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (credit_used == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register plus the registered read strobe and address.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            rd_en   <= 1'b0;
            rd_addr <= '0;
        end else begin
            state_q <= state_d;
            rd_en   <= issue_d;
            if (issue_d) begin
                rd_addr <= (state_q == S_IDLE) ? '0 : rd_addr + ADDR_W'(1);
            end
        end
    end

    // Pixel pipeline control: valid and last-marker shift with each pixel.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            vld_p3  <= 1'b0;
            last_p0 <= 1'b0;
            last_p1 <= 1'b0;
            last_p2 <= 1'b0;
            last_p3 <= 1'b0;
        end else begin
            vld_p0  <= rd_en;
            last_p0 <= rd_en && (rd_addr == LAST_ADDR);
            vld_p1  <= vld_p0;
            last_p1 <= last_p0;
            vld_p2  <= vld_p1;
            last_p2 <= last_p1;
            vld_p3  <= vld_p2;
            last_p3 <= last_p2;
        end
    end

    // Converter input only changes when fresh RAM data arrives.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            conv_int_p1 <= '0;
        end else if (vld_p0) begin
            conv_int_p1 <= signed'(rd_data);
        end
    end

    // Issued-but-not-pushed pixel count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            inflight <= '0;
        end else begin
            case ({rd_en, push})
                2'b10:   inflight <= inflight + 2'd1;
                2'b01:   inflight <= inflight - 2'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage: float result with its last-pixel marker.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {last_p3, conv_float};
        end
    end

endmodule

// File: tb/tb_frame_float_sequencer.sv
// Directed bench for frame_float_sequencer: frame RAM and a two-cycle-hold
// converter model drive the DUT; a negedge monitor logs reads and beats.
module tb_frame_float_sequencer;

    localparam int PIXELS     = 768;
    localparam int ADDR_W     = 10;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic              m_ready = 1'b1;
    logic              busy, done, rd_en, m_valid, m_last;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_data = '0;
    logic [15:0]       conv_int;
    logic [31:0]       conv_float, m_data;

    int checks = 0;
    int failures = 0;

    frame_float_sequencer #(
        .PIXELS(PIXELS), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .conv_int(conv_int), .conv_float(conv_float),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    // Reference int16 -> IEEE-754 single conversion (exact for 16-bit ints).
    function automatic logic [31:0] i2f(input logic signed [15:0] v);
        int          iv, av, msb;
        logic [31:0] m;
        logic [7:0]  e;
        iv = int'(v);
        if (iv == 0) return 32'h0;
        av = (iv < 0) ? -iv : iv;
        msb = 0;
        for (int k = 0; k < 17; k++) if (av[k]) msb = k;
        m = 32'(av) << (23 - msb);
        e = 8'(127 + msb);
        return {v[15], e, m[22:0]};
    endfunction

    // Frame RAM with one-cycle read latency.
    logic [15:0] ram [1024];
    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    // Converter: result is only correct when its input was stable for the
    // two preceding cycles, otherwise it returns an obviously bad pattern.
    logic [15:0] cv_a = '0, cv_b = '0;
    always @(posedge clk) begin
        cv_a <= conv_int;
        cv_b <= cv_a;
    end
    assign conv_float = (cv_a == cv_b) ? i2f(cv_a) : 32'hFFFF_FFFF;

    // Monitor.
    int          cyc = 0;
    logic [31:0] q_data[$];
    logic        q_last[$];
    int          q_dcyc[$];
    int          q_addr[$];
    int          q_acyc[$];
    int          done_cnt = 0, done_cyc = -1, last_hs_cyc = -1;
    int          hold_viol = 0, ovf = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            q_data.push_back(m_data);
            q_last.push_back(m_last);
            q_dcyc.push_back(cyc);
            if (m_last) last_hs_cyc <= cyc;
        end
        if (rd_en) begin
            q_addr.push_back(int'(rd_addr));
            q_acyc.push_back(cyc);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (stall_prev && !(m_valid && (m_data == prev_data))) hold_viol <= hold_viol + 1;
        stall_prev <= m_valid && !m_ready && resetn;
        prev_data  <= m_data;
        if (int'(dut.fifo_count) > FIFO_DEPTH) ovf <= ovf + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Run until a new done pulse (bounded). mode 1 = random m_ready.
    // inject 1 = pulse start during RUN, DRAIN and the DONE cycle.
    task automatic wait_done(input int mode, input int inject, input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 20000) begin
            m_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            start   = (inject == 1) && (n == 99 || n == 1536 || n == 1540);
            step();
            n++;
        end
        start   = 1'b0;
        m_ready = 1'b1;
    endtask

    // Compare a logged frame starting at queue offsets against the ramp.
    task automatic check_ramp_frame(input string tag, input int bq, input int ba);
        int bad, badaddr, lastn;
        bad = 0; badaddr = 0; lastn = 0;
        for (int i = 0; i < PIXELS; i++) begin
            if (q_data.size() <= bq + i || q_data[bq + i] !== i2f(16'(i - 384))) bad++;
            if (q_addr.size() <= ba + i || q_addr[ba + i] != i) badaddr++;
            if (q_last.size() > bq + i && q_last[bq + i]) lastn++;
        end
        check({tag, "_beats"}, 32'(q_data.size() - bq), 32'(PIXELS));
        check({tag, "_reads"}, 32'(q_addr.size() - ba), 32'(PIXELS));
        check({tag, "_data_mismatches"}, 32'(bad), 32'd0);
        check({tag, "_addr_mismatches"}, 32'(badaddr), 32'd0);
        check({tag, "_last_count"}, 32'(lastn), 32'd1);
    endtask

    initial begin
        int d0, bq, ba, c1, bad, n, hv0, ov0, na;

        for (int i = 0; i < 1024; i++) ram[i] = 16'(i - 384);

        // Reset state
        resetn = 1'b0;
        step(); step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_conv_int", 32'(conv_int), 32'd0);
        resetn = 1'b1;
        step();

        // Ramp frame at full rate
        d0 = done_cnt; bq = q_data.size(); ba = q_addr.size();
        kick();
        c1 = cyc;
        check("ramp_busy_c1", 32'(busy), 32'd1);
        check("ramp_rd_en_c1", 32'(rd_en), 32'd1);
        check("ramp_rd_addr_c1", 32'(rd_addr), 32'd0);
        wait_done(0, 0, d0);
        check("ramp_done_count", 32'(done_cnt - d0), 32'd1);
        check_ramp_frame("ramp", bq, ba);
        check("ramp_beat0", q_data[bq], 32'hC3C0_0000);
        check("ramp_beat384", q_data[bq + 384], 32'h0000_0000);
        check("ramp_beat385", q_data[bq + 385], 32'h3F80_0000);
        check("ramp_beat767", q_data[bq + 767], 32'h43BF_8000);
        check("ramp_last_on_767", 32'(q_last[bq + 767]), 32'd1);
        check("ramp_first_rd_cyc", 32'(q_acyc[ba]), 32'(c1));
        check("ramp_first_valid_lat", 32'(q_dcyc[bq] - q_acyc[ba]), 32'd5);
        check("ramp_issue_span", 32'(q_acyc[ba + 767] - q_acyc[ba]), 32'd1534);
        check("ramp_done_after_last", 32'(done_cyc - last_hs_cyc), 32'd1);
        check("ramp_done_cyc", 32'(done_cyc - c1), 32'd1540);
        check("ramp_busy_after", 32'(busy), 32'd0);

        // Hold-time frame with alternating extremes
        for (int i = 0; i < 1024; i++) ram[i] = i[0] ? 16'h7FFF : 16'h0001;
        d0 = done_cnt; bq = q_data.size();
        kick();
        wait_done(0, 0, d0);
        bad = 0;
        for (int i = 0; i < PIXELS; i++)
            if (q_data.size() <= bq + i || q_data[bq + i] !== (i[0] ? 32'h46FF_FE00 : 32'h3F80_0000)) bad++;
        check("hold_beats", 32'(q_data.size() - bq), 32'(PIXELS));
        check("hold_beat0", q_data[bq], 32'h3F80_0000);
        check("hold_beat1", q_data[bq + 1], 32'h46FF_FE00);
        check("hold_mismatches", 32'(bad), 32'd0);
        for (int i = 0; i < 1024; i++) ram[i] = 16'(i - 384);

        // Backpressure: m_ready low for 50 cycles after start
        d0 = done_cnt; bq = q_data.size(); ba = q_addr.size(); hv0 = hold_viol;
        m_ready = 1'b0;
        kick();
        for (int i = 0; i < 50; i++) step();
        check("bp_reads_stalled", 32'(q_addr.size() - ba), 32'(FIFO_DEPTH));
        check("bp_rd_en_low", 32'(rd_en), 32'd0);
        check("bp_m_valid", 32'(m_valid), 32'd1);
        check("bp_m_data_pix0", m_data, 32'hC3C0_0000);
        check("bp_hold_viol", 32'(hold_viol - hv0), 32'd0);
        wait_done(0, 0, d0);
        check("bp_done_count", 32'(done_cnt - d0), 32'd1);
        check_ramp_frame("bp", bq, ba);

        // Random m_ready
        d0 = done_cnt; bq = q_data.size(); ba = q_addr.size(); hv0 = hold_viol; ov0 = ovf;
        kick();
        wait_done(1, 0, d0);
        check("rnd_done_count", 32'(done_cnt - d0), 32'd1);
        check_ramp_frame("rnd", bq, ba);
        check("rnd_overflow", 32'(ovf - ov0), 32'd0);
        check("rnd_hold_viol", 32'(hold_viol - hv0), 32'd0);

        // Stray start pulses during RUN, DRAIN and DONE
        d0 = done_cnt; bq = q_data.size(); ba = q_addr.size();
        kick();
        wait_done(0, 1, d0);
        na = q_addr.size();
        for (int i = 0; i < 10; i++) step();
        check("stray_done_count", 32'(done_cnt - d0), 32'd1);
        check("stray_busy_after", 32'(busy), 32'd0);
        check("stray_no_new_reads", 32'(q_addr.size() - na), 32'd0);
        check_ramp_frame("stray", bq, ba);
        d0 = done_cnt; bq = q_data.size(); ba = q_addr.size();
        kick();
        wait_done(0, 0, d0);
        check("next_first_addr", 32'(q_addr[ba]), 32'd0);
        check_ramp_frame("next", bq, ba);

        // Reset mid-frame at pixel 200
        d0 = done_cnt; ba = q_addr.size();
        kick();
        n = 0;
        while (q_addr.size() - ba < 201 && n < 5000) begin
            step();
            n++;
        end
        check("mid_reached_pix200", 32'(q_addr.size() - ba), 32'd201);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rd_en", 32'(rd_en), 32'd0);
        step(); step();
        check("mid_no_done", 32'(done_cnt - d0), 32'd0);
        d0 = done_cnt; bq = q_data.size(); ba = q_addr.size();
        kick();
        wait_done(0, 0, d0);
        check("mid_done_count", 32'(done_cnt - d0), 32'd1);
        check_ramp_frame("mid", bq, ba);
        check("mid_beat0", q_data[bq], 32'hC3C0_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
